// File: rtl/trng_ctrl.sv
// Entropy-unit sequencer: warm-up, von-Neumann bit packing into bytes, online health tests.
// Byte valid on the edge sampling the 8th strobe; o_valid/o_data hold until i_ready, strobes dropped meanwhile.
module trng_ctrl #(
   parameter int unsigned WARMUP_CYCLES = 16,
   parameter int unsigned REP_LIMIT     = 64,
   parameter int unsigned TIMEOUT       = 1023
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   output logic       o_ent_en,
   input  logic       i_ent_chain_done,
   input  logic       i_raw,
   input  logic       i_bit,
   input  logic       i_bit_valid,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy,
   output logic [1:0] o_err,
   input  logic       i_err_clr
);

   localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
   localparam int unsigned RW = $clog2(REP_LIMIT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAULT} state_t;

   state_t        state_q;
   logic [WW-1:0] warm_cnt_q;
   logic [RW-1:0] rep_cnt_q;
   logic [TW-1:0] to_cnt_q;
   logic [2:0]    bit_cnt_q;
   logic [6:0]    sr_q;
   logic          raw_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ent_en_q;
   logic          busy_q;
   logic [1:0]    err_q;

   logic [WW-1:0] warm_cnt_d;
   logic [RW-1:0] rep_cnt_d;
   logic [TW-1:0] to_cnt_d;
   logic          rep_fail;
   logic          to_fail;

   // Warm-up count starts on the first chain_done and then runs freely.
   always_comb begin
      warm_cnt_d = warm_cnt_q;
      if (i_ent_chain_done || warm_cnt_q != '0)
         warm_cnt_d = warm_cnt_q + WW'(1);
      rep_cnt_d = RW'(1);
      if (i_raw == raw_q)
         rep_cnt_d = (rep_cnt_q == RW'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + RW'(1);
      to_cnt_d = i_bit_valid ? '0 : to_cnt_q + TW'(1);
      rep_fail = (rep_cnt_d == RW'(REP_LIMIT));
      to_fail  = (to_cnt_d == TW'(TIMEOUT));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         warm_cnt_q <= '0;
         rep_cnt_q  <= '0;
         to_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         sr_q       <= '0;
         raw_q      <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ent_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         raw_q <= i_raw;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_q    <= S_WARMUP;
                  ent_en_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  warm_cnt_q <= '0;
               end
            end
            S_WARMUP: begin
               if (!i_start) begin
                  state_q    <= S_IDLE;
                  ent_en_q   <= 1'b0;
                  busy_q     <= 1'b0;
                  warm_cnt_q <= '0;
               end else if (warm_cnt_d == WW'(WARMUP_CYCLES)) begin
                  state_q    <= S_COLLECT;
                  warm_cnt_q <= '0;
                  rep_cnt_q  <= RW'(1);
                  to_cnt_q   <= '0;
                  bit_cnt_q  <= '0;
                  sr_q       <= '0;
               end else begin
                  warm_cnt_q <= warm_cnt_d;
               end
            end
            S_COLLECT: begin
               // A health fault outranks both an abort and a completing byte.
               if (rep_fail || to_fail) begin
                  state_q   <= S_FAULT;
                  err_q     <= err_q | {to_fail, rep_fail};
                  ent_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  rep_cnt_q <= '0;
                  to_cnt_q  <= '0;
                  bit_cnt_q <= '0;
                  sr_q      <= '0;
               end else if (!i_start) begin
                  state_q   <= S_IDLE;
                  ent_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  rep_cnt_q <= '0;
                  to_cnt_q  <= '0;
                  bit_cnt_q <= '0;
                  sr_q      <= '0;
               end else begin
                  rep_cnt_q <= rep_cnt_d;
                  to_cnt_q  <= to_cnt_d;
                  if (i_bit_valid) begin
                     sr_q <= {sr_q[5:0], i_bit};
                     if (bit_cnt_q == 3'd7) begin
                        data_q    <= {sr_q, i_bit};
                        valid_q   <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= S_HOLD;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  if (i_start) begin
                     state_q   <= S_COLLECT;
                     rep_cnt_q <= RW'(1);
                     to_cnt_q  <= '0;
                     sr_q      <= '0;
                  end else begin
                     state_q  <= S_IDLE;
                     ent_en_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end
               end
            end
            S_FAULT: begin
               if (i_err_clr) begin
                  err_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_ent_en = ent_en_q;
   assign o_data   = data_q;
   assign o_valid  = valid_q;
   assign o_busy   = busy_q;
   assign o_err    = err_q;

endmodule
